// File: rtl/interpolator_scheduler.sv
// Sequences one silencer-interpolator burst per trigger: source-memory addressing aligned to
// the interpolator's transducer counter, DIN_VALID issue, DOUT_VALID checking and a one-deep trigger queue.
module interpolator_scheduler #(
  parameter int unsigned DEPTH               = 249,
  parameter int unsigned SRC_LATENCY         = 1,
  parameter logic [15:0] DEFAULT_UPDATE_RATE = 16'd256,
  parameter int unsigned WATCHDOG            = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        TRIG,
  input  logic        ENABLE,
  input  logic        SETTING_VALID,
  input  logic [15:0] UPDATE_RATE_IN,
  output logic [15:0] UPDATE_RATE,
  output logic [7:0]  SRC_ADDR,
  output logic        SRC_EN,
  output logic        DIN_VALID,
  input  logic        DOUT_VALID_IN,
  output logic        BUSY,
  output logic        DONE,
  output logic        OVERRUN,
  output logic        ERR,
  input  logic        FLAG_CLR
);

  // Timer reads 0 in the ISSUE cycle; expiry at this offset raises ERR one cycle later.
  localparam int unsigned TMO = DEPTH + 1 + WATCHDOG;
  localparam int unsigned TW  = $clog2(TMO + 1);

  localparam logic [7:0]    LAST_ADDR = 8'(DEPTH);
  localparam logic [7:0]    LAST_PRE  = 8'(SRC_LATENCY - 1);
  localparam logic [8:0]    NOM_LEN   = 9'(DEPTH);
  localparam logic [TW-1:0] TMO_T     = TW'(TMO);

  typedef enum logic [2:0] {IDLE, PREFETCH, ISSUE, STREAM, DRAIN} state_t;

  state_t        state, state_nx;
  logic [7:0]    addr;
  logic [8:0]    vcount;
  logic [TW-1:0] timer;
  logic [15:0]   shadow;
  logic          dout_q;
  logic          pending, pending_nx;
  logic          start, fall;
  logic          done_set, err_set, ovr_set;
  logic          addressing, addressing_nx, tracking;

  always_comb begin
    state_nx      = state;
    pending_nx    = pending;
    start         = 1'b0;
    done_set      = 1'b0;
    err_set       = 1'b0;
    ovr_set       = 1'b0;
    fall          = dout_q & ~DOUT_VALID_IN;

    case (state)
      IDLE: begin
        if (ENABLE && (TRIG || pending)) begin
          start    = 1'b1;
          state_nx = PREFETCH;
        end
      end
      PREFETCH: begin
        if (addr == LAST_PRE) state_nx = ISSUE;
      end
      ISSUE: begin
        state_nx = (addr == LAST_ADDR) ? DRAIN : STREAM;
      end
      STREAM: begin
        if (addr == LAST_ADDR) state_nx = DRAIN;
      end
      DRAIN: begin
        if (fall) begin
          state_nx = IDLE;
          if (vcount == NOM_LEN) done_set = 1'b1;
          else                   err_set  = 1'b1;
        end else if (timer == TMO_T) begin
          state_nx = IDLE;
          err_set  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // A start from pending does not swallow a same-cycle TRIG: it re-arms pending.
    if (start && pending) begin
      pending_nx = TRIG;
    end else if (start) begin
      pending_nx = 1'b0;
    end else if (TRIG && ENABLE) begin
      pending_nx = 1'b1;
      ovr_set    = pending;
    end

    addressing    = (state == PREFETCH) || (state == ISSUE) || (state == STREAM);
    addressing_nx = (state_nx == PREFETCH) || (state_nx == ISSUE) || (state_nx == STREAM);
    tracking      = (state == ISSUE) || (state == STREAM) || (state == DRAIN);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      pending     <= 1'b0;
      addr        <= '0;
      vcount      <= '0;
      timer       <= '0;
      dout_q      <= 1'b0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
      OVERRUN     <= 1'b0;
      shadow      <= DEFAULT_UPDATE_RATE;
      UPDATE_RATE <= DEFAULT_UPDATE_RATE;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      DONE    <= done_set;
      ERR     <= err_set | (ERR & ~FLAG_CLR);
      OVERRUN <= ovr_set | (OVERRUN & ~FLAG_CLR);

      if (SETTING_VALID) shadow <= UPDATE_RATE_IN;
      if (state == PREFETCH && state_nx == ISSUE) UPDATE_RATE <= shadow;

      if (!addressing_nx)  addr <= '0;
      else if (addressing) addr <= addr + 8'd1;

      // DOUT_VALID starts returning before addressing ends, so counting spans ISSUE..DRAIN.
      if (tracking) begin
        dout_q <= DOUT_VALID_IN;
        if (DOUT_VALID_IN && vcount != '1) vcount <= vcount + 9'd1;
        if (timer != '1) timer <= timer + 1'b1;
      end else begin
        dout_q <= 1'b0;
        vcount <= '0;
        timer  <= '0;
      end
    end
  end

  assign SRC_ADDR  = addr;
  assign SRC_EN    = addressing;
  assign DIN_VALID = (state == ISSUE);
  assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_interpolator_scheduler.sv
// Bench for interpolator_scheduler: interpolator return model, burst scoreboard,
// a vector table of burst outcomes and hand-written queue/reset/enable sequences.
module tb_interpolator_scheduler;

  localparam int          DEPTH    = 249;
  localparam int          LAT      = 1;
  localparam int          WD       = 16;
  localparam logic [15:0] DEF_RATE = 16'h0100;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        TRIG = 1'b0;
  logic        ENABLE = 1'b0;
  logic        SETTING_VALID = 1'b0;
  logic [15:0] UPDATE_RATE_IN = '0;
  logic        DOUT_VALID_IN = 1'b0;
  logic        FLAG_CLR = 1'b0;
  logic [15:0] UPDATE_RATE;
  logic [7:0]  SRC_ADDR;
  logic        SRC_EN, DIN_VALID, BUSY, DONE, OVERRUN, ERR;

  interpolator_scheduler #(
    .DEPTH(DEPTH),
    .SRC_LATENCY(LAT),
    .DEFAULT_UPDATE_RATE(DEF_RATE),
    .WATCHDOG(WD)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .TRIG(TRIG), .ENABLE(ENABLE),
    .SETTING_VALID(SETTING_VALID), .UPDATE_RATE_IN(UPDATE_RATE_IN),
    .UPDATE_RATE(UPDATE_RATE), .SRC_ADDR(SRC_ADDR), .SRC_EN(SRC_EN),
    .DIN_VALID(DIN_VALID), .DOUT_VALID_IN(DOUT_VALID_IN), .BUSY(BUSY),
    .DONE(DONE), .OVERRUN(OVERRUN), .ERR(ERR), .FLAG_CLR(FLAG_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] rate;
    int          len;
    logic        ok;
  } exp_t;

  typedef struct packed {
    logic        set_en;
    logic [15:0] setting;
    int          len;
    logic        ok;
    logic [15:0] rate;
  } vec_t;

  exp_t exp_q[$];
  exp_t cur;
  vec_t vecs[6];

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t0 = 0;
  bit   in_burst = 0;
  bit   m_act = 0;
  int   m_t0 = 0;
  int   m_len = 0;
  bit   prev_en = 0;
  int   prev_addr = 0;
  int   run = 0;
  logic prev_err = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_trig();
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
  endtask

  task automatic set_rate(input logic [15:0] r);
    SETTING_VALID  = 1'b1;
    UPDATE_RATE_IN = r;
    tick();
    SETTING_VALID  = 1'b0;
  endtask

  task automatic clear_flags();
    FLAG_CLR = 1'b1;
    tick();
    FLAG_CLR = 1'b0;
  endtask

  task automatic expect_burst(input logic [15:0] r, input int len, input logic ok);
    exp_t e;
    e.rate = r;
    e.len  = len;
    e.ok   = ok;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int budget, input bit need_empty);
    int n;
    n = 0;
    while ((BUSY || in_burst || (need_empty && exp_q.size() != 0)) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_within_budget", n < budget, 1);
  endtask

  // Interpolator model: DOUT_VALID high from t0+2 for the scripted number of cycles.
  initial forever begin
    @(posedge CLK);
    #1;
    DOUT_VALID_IN = m_act && (cyc >= m_t0 + 2) && (cyc <= m_t0 + 1 + m_len);
  end

  // Monitor: address stream, issue alignment, rate stability, burst end timing.
  always @(negedge CLK) begin
    if (!RST_N) begin
      in_burst = 0;
      m_act    = 0;
      prev_en  = 0;
      run      = 0;
      prev_err = ERR;
    end else begin
      if (SRC_EN) begin
        chk("src_addr", SRC_ADDR, prev_en ? prev_addr + 1 : 0);
        run       = prev_en ? run + 1 : 1;
        prev_addr = SRC_ADDR;
      end else if (prev_en) begin
        chk("src_run_len", run, DEPTH + 1);
      end
      prev_en = SRC_EN;

      if (DIN_VALID) begin
        chk("issue_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          cur      = exp_q.pop_front();
          t0       = cyc;
          in_burst = 1;
          m_t0     = cyc;
          m_len    = cur.len;
          m_act    = 1;
          chk("issue_addr", SRC_ADDR, LAT);
          chk("issue_src_en", SRC_EN, 1);
          chk("issue_rate", UPDATE_RATE, cur.rate);
        end
      end else if (in_burst) begin
        chk("rate_hold", UPDATE_RATE, cur.rate);
      end

      if (DONE || (ERR && !prev_err)) begin
        chk("end_in_burst", in_burst, 1);
        if (in_burst) begin
          chk("end_kind_done", DONE, cur.ok);
          chk("end_cycle", cyc - t0, (cur.len == 0) ? DEPTH + 2 + WD : cur.len + 3);
          chk("busy_at_end", BUSY, 0);
          in_burst = 0;
        end
      end else if (in_burst && (cyc - t0 > DEPTH + WD + 10)) begin
        chk("burst_timeout", cyc - t0, DEPTH + WD + 10);
        in_burst = 0;
      end
      prev_err = ERR;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int t0r;

    vecs[0] = '{1'b0, 16'h0000, DEPTH,     1'b1, 16'h0040};
    vecs[1] = '{1'b1, 16'h0ABC, DEPTH,     1'b1, 16'h0ABC};
    vecs[2] = '{1'b0, 16'h0000, DEPTH - 1, 1'b0, 16'h0ABC};
    vecs[3] = '{1'b0, 16'h0000, 0,         1'b0, 16'h0ABC};
    vecs[4] = '{1'b1, 16'hFFFF, DEPTH + 1, 1'b0, 16'hFFFF};
    vecs[5] = '{1'b1, 16'h0001, DEPTH,     1'b1, 16'h0001};

    repeat (3) tick();
    chk("rst_update_rate", UPDATE_RATE, DEF_RATE);
    chk("rst_src_addr", SRC_ADDR, 0);
    chk("rst_src_en", SRC_EN, 0);
    chk("rst_din_valid", DIN_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_err", ERR, 0);
    RST_N  = 1'b1;
    ENABLE = 1'b1;
    tick();

    // New setting mid-stream is held off until the next burst's issue.
    expect_burst(16'h0100, DEPTH, 1'b1);
    pulse_trig();
    repeat (30) tick();
    set_rate(16'h0040);
    chk("rate_unchanged_mid_burst", UPDATE_RATE, 16'h0100);
    wait_idle(400, 1);
    chk("rate_held_after_burst", UPDATE_RATE, 16'h0100);
    chk("err_clean_burst", ERR, 0);
    expect_burst(16'h0040, DEPTH, 1'b1);
    pulse_trig();
    wait_idle(400, 1);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].set_en) set_rate(vecs[i].setting);
      clear_flags();
      chk("err_cleared", ERR, 0);
      expect_burst(vecs[i].rate, vecs[i].len, vecs[i].ok);
      pulse_trig();
      wait_idle(400, 1);
      chk("err_sticky", ERR, !vecs[i].ok);
    end
    clear_flags();

    // Setting in the ISSUE cycle belongs to the following burst.
    expect_burst(16'h0001, DEPTH, 1'b1);
    pulse_trig();
    n = 0;
    while (!DIN_VALID && n < 10) begin
      tick();
      n++;
    end
    chk("issue_seen", DIN_VALID, 1);
    set_rate(16'h0777);
    chk("rate_not_taken_at_issue", UPDATE_RATE, 16'h0001);
    wait_idle(400, 1);
    expect_burst(16'h0777, DEPTH, 1'b1);
    pulse_trig();
    wait_idle(400, 1);

    // Three triggers in one burst: one queued, one dropped.
    expect_burst(16'h0777, DEPTH, 1'b1);
    pulse_trig();
    repeat (20) tick();
    expect_burst(16'h0777, DEPTH, 1'b1);
    pulse_trig();
    chk("no_overrun_on_queue", OVERRUN, 0);
    repeat (20) tick();
    pulse_trig();
    chk("overrun_set", OVERRUN, 1);
    TRIG     = 1'b1;
    FLAG_CLR = 1'b1;
    tick();
    TRIG     = 1'b0;
    FLAG_CLR = 1'b0;
    chk("overrun_set_wins", OVERRUN, 1);
    n = 0;
    while (!DONE && n < 400) begin
      tick();
      n++;
    end
    chk("first_done_seen", DONE, 1);
    tick();
    chk("second_start_after_done", SRC_EN, 1);
    chk("second_start_addr", SRC_ADDR, 0);
    wait_idle(400, 1);
    chk("overrun_sticky", OVERRUN, 1);
    clear_flags();
    chk("overrun_cleared", OVERRUN, 0);

    // ENABLE low: triggers ignored, in-flight burst completes, pending waits.
    ENABLE = 1'b0;
    pulse_trig();
    repeat (5) tick();
    chk("disabled_no_busy", BUSY, 0);
    chk("disabled_no_src_en", SRC_EN, 0);
    chk("disabled_no_din", DIN_VALID, 0);
    ENABLE = 1'b1;
    expect_burst(16'h0777, DEPTH, 1'b1);
    pulse_trig();
    repeat (50) tick();
    ENABLE = 1'b0;
    pulse_trig();
    wait_idle(400, 1);
    chk("overrun_not_set_when_disabled", OVERRUN, 0);
    ENABLE = 1'b1;
    expect_burst(16'h0777, DEPTH, 1'b1);
    pulse_trig();
    repeat (10) tick();
    expect_burst(16'h0777, DEPTH, 1'b1);
    pulse_trig();
    ENABLE = 1'b0;
    wait_idle(400, 0);
    repeat (10) tick();
    chk("no_start_while_disabled", BUSY, 0);
    chk("pending_burst_waiting", exp_q.size(), 1);
    ENABLE = 1'b1;
    tick();
    chk("pending_starts_on_enable", SRC_EN, 1);
    wait_idle(400, 1);

    // Reset mid-burst with pending and OVERRUN set.
    set_rate(16'h0040);
    expect_burst(16'h0040, DEPTH, 1'b1);
    pulse_trig();
    n = 0;
    while (!DIN_VALID && n < 10) begin
      tick();
      n++;
    end
    chk("reset_burst_issue_seen", DIN_VALID, 1);
    t0r = cyc;
    repeat (10) tick();
    pulse_trig();
    repeat (10) tick();
    pulse_trig();
    chk("overrun_before_reset", OVERRUN, 1);
    while (cyc < t0r + 100) tick();
    RST_N = 1'b0;
    tick();
    chk("mid_rst_update_rate", UPDATE_RATE, DEF_RATE);
    chk("mid_rst_src_addr", SRC_ADDR, 0);
    chk("mid_rst_src_en", SRC_EN, 0);
    chk("mid_rst_din_valid", DIN_VALID, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_done", DONE, 0);
    chk("mid_rst_overrun", OVERRUN, 0);
    chk("mid_rst_err", ERR, 0);
    RST_N = 1'b1;
    repeat (20) tick();
    chk("pending_cleared_by_reset", BUSY, 0);
    expect_burst(16'h0100, DEPTH, 1'b1);
    pulse_trig();
    wait_idle(400, 1);
    chk("post_reset_err", ERR, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interpolator_scheduler.md
Name: interpolator_scheduler

Overview:
- Sequences one burst of the silencer intensity interpolator per sampling trigger.
- Generates the source-memory read addresses so that INTENSITY_IN reaches the interpolator aligned with its internal transducer counter.
- Issues the single-cycle DIN_VALID, holds the update rate stable for the whole burst, checks the returned DOUT_VALID burst, and queues or flags triggers that arrive while a burst is in flight.

Parameters:
- DEPTH, 249: last transducer index; each burst covers indices 0..DEPTH.
- SRC_LATENCY, 1: read latency of the source memory, in cycles (1..4).
- DEFAULT_UPDATE_RATE, 16'd256: update rate applied after reset.
- WATCHDOG, 16: extra cycles allowed beyond nominal burst completion before the burst is declared failed.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous, active-low reset.
- TRIG  in  1  sampling tick, single-cycle pulse.
- ENABLE  in  1  when low, TRIG is ignored.
- SETTING_VALID  in  1  latches UPDATE_RATE_IN into the shadow register.
- UPDATE_RATE_IN  in  16  new update rate.
- UPDATE_RATE  out  16  rate driven to the interpolator; changes only at issue.
- SRC_ADDR  out  8  source-memory read address (transducer index).
- SRC_EN  out  1  SRC_ADDR is valid.
- DIN_VALID  out  1  burst start pulse to the interpolator.
- DOUT_VALID_IN  in  1  DOUT_VALID returned by the interpolator.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle pulse when a burst completes correctly.
- OVERRUN  out  1  sticky: a trigger was dropped.
- ERR  out  1  sticky: returned burst had the wrong length, or the watchdog expired.
- FLAG_CLR  in  1  clears OVERRUN and ERR.

Behaviour:
- Reset (RST_N low at a CLK edge):
  - State goes to IDLE; pending and both stickies clear.
  - UPDATE_RATE and shadow = DEFAULT_UPDATE_RATE.
  - All other outputs = 0.
  - Reset mid-burst aborts immediately; no DONE.
- Timing: let t0 be the cycle in which DIN_VALID is high.
  - SRC_EN is high and SRC_ADDR = k at cycle t0 - SRC_LATENCY + k, for k = 0..DEPTH (DEPTH+1 consecutive cycles, no gaps).
  - As a result, INTENSITY_IN for index k is valid at cycle t0 + k.
- States:
  - IDLE: on start (TRIG&ENABLE, or pending set), go to PREFETCH and begin addressing at index 0. A start does not consume a TRIG in the same cycle; that TRIG sets pending.
  - PREFETCH: lasts SRC_LATENCY cycles, then ISSUE.
  - ISSUE: one cycle. DIN_VALID = 1; UPDATE_RATE <= shadow, registered at the same edge that raises DIN_VALID. Then STREAM.
  - STREAM: continue until SRC_ADDR = DEPTH has been emitted, then DRAIN.
  - DRAIN: count the cycles with DOUT_VALID_IN high (9-bit counter).
    - On the DOUT_VALID_IN falling edge: if count == DEPTH, pulse DONE; else set ERR. Either way, return to IDLE.
    - If t0 + DEPTH + 2 + WATCHDOG is reached without a falling edge: set ERR and return to IDLE.
- Nominal DOUT_VALID_IN: high from t0+2 through t0+DEPTH+1. DONE is at t0+DEPTH+3.
- Trigger queue (one deep):
  - TRIG&ENABLE while BUSY or starting: set pending.
  - TRIG&ENABLE while pending is already set: set OVERRUN; the trigger is dropped.
  - Pending is consumed on the IDLE->PREFETCH transition.
  - ENABLE low: TRIG is ignored and the in-flight burst completes. Pending is kept, but no start occurs while ENABLE is low.
- Settings:
  - SETTING_VALID updates the shadow at any time.
  - UPDATE_RATE changes only in the ISSUE cycle, so it is constant from t0 through burst end.
  - SETTING_VALID coincident with ISSUE: the new value is taken by the next burst, not the current one.
- Flags: FLAG_CLR coincident with a new flag event leaves the flag set (the set wins).
- Width rules:
  - SRC_ADDR is 8 bits; DEPTH ≤ 255.
  - The watchdog counter is wide enough for DEPTH + 2 + WATCHDOG, with no wrap.

Test Plan:
- Single TRIG with SRC_LATENCY=1 -> SRC_ADDR 0..249 at t0-1..t0+248; DIN_VALID at t0; model DOUT_VALID_IN high t0+2..t0+250 -> DONE at t0+252; ERR=0.
- SETTING_VALID=0x0040 during STREAM, then second TRIG -> UPDATE_RATE stays 0x0100 for the first burst; changes to 0x0040 at the second burst's ISSUE cycle.
- Three TRIG pulses during one burst -> second burst starts the cycle after DONE; OVERRUN=1 after the third; FLAG_CLR clears it.
- Model returns 248 DOUT_VALID_IN cycles -> ERR=1, no DONE. Model returns none -> ERR=1 at t0+267; BUSY falls.
- RST_N low at t0+100 -> next cycle all outputs 0 and UPDATE_RATE=0x0100; a subsequent TRIG runs a clean burst.
- ENABLE=0 with TRIG -> no SRC_EN, no DIN_VALID; ENABLE=0 mid-burst -> burst completes with DONE.
